uart_send: RTL and testbench
============================

Name: uart_send

Overview:
- UART transmitter stage downstream of the uart_sys FIFO data_out port.
- Acts as an Avalon-MM read master on the FIFO read port (read/waitrequest).
- Pops one byte at a time and serializes it on tx_wire as 8N1: start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
- Bit timing comes from the shared baud_tick strobe that also drives uart_recv.

Parameters:
DATA_BITS, 8, width of data_out and number of data bits per frame.
OVERSAMPLE, 16, number of baud_tick pulses per serial bit period (matches receiver tick rate).
STOP_BITS, 1, number of stop bit periods per frame (1 or 2).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
baud_tick  in  1  single-cycle strobe at OVERSAMPLE x baud rate.
data_out  in  DATA_BITS  FIFO read data; valid in the cycle data_out_read=1 and data_out_wait=0.
data_out_wait  in  1  FIFO waitrequest; 1 = read not accepted this cycle (FIFO empty).
data_out_read  out  1  FIFO read request.
tx_wire  out  1  serial output; idle/mark = 1.
busy  out  1  1 while a frame (start..last stop) is on the line.
tx_done  out  1  one-cycle pulse after the last stop bit period ends.

Behaviour:
- Reset state, taking effect on the edge rst is sampled high:
  - tx_wire=1, data_out_read=0, busy=0, tx_done=0.
  - State = IDLE; tick counter, bit counter and shift register cleared.
- All outputs are registered.
- State machine:
  - IDLE: unconditionally -> FETCH next cycle.
  - FETCH: data_out_read=1, tx_wire=1, busy=0.
    - data_out_wait=1: stay in FETCH and hold read high (Avalon rule: read held until accepted).
    - data_out_wait=0: capture data_out into the shift register, go to START. data_out_read=0 from the next cycle.
  - START: tx_wire=0, busy=1.
  - DATA: tx_wire=shift[0]. On each bit end, shift right and increment the bit counter. After bit DATA_BITS-1 ends -> STOP.
  - STOP: tx_wire=1, busy=1. After STOP_BITS bit periods -> FETCH, with tx_done=1 for exactly that transition cycle.
- Bit timing:
  - The tick counter clears on entry to every bit.
  - It increments on each baud_tick.
  - A bit ends in the cycle the OVERSAMPLE-th baud_tick since bit entry is sampled.
  - Every bit therefore lasts exactly OVERSAMPLE baud_ticks.
  - baud_tick is ignored in IDLE and FETCH.
- Back-to-back frames: the stop bit end leads straight to FETCH. With the FIFO non-empty, the line stays high for exactly 1 extra clk before the next start bit (tx_wire=0 the cycle after capture).
- FIFO empty: remain in FETCH indefinitely, with tx_wire=1, busy=0 and data_out_read=1.
- Reset mid-frame: tx_wire=1 on the next edge. The byte in flight is discarded and not retransmitted; the FIFO is not re-read for it.
- Single-pop guarantee: one accepted read (read=1 & wait=0) per frame; no read is asserted outside FETCH.
- Counters:
  - Tick counter width is clog2(OVERSAMPLE).
  - Bit counter width is clog2(max(DATA_BITS, STOP_BITS)).
  - No wrap occurs outside a bit end.

Test Plan:
1. OVERSAMPLE=16, baud_tick every 4 clk, FIFO holds 0x55, wait=0 → one read pulse. tx_wire sequence 0,1,0,1,0,1,0,1,0,1, each level 64 clk. Then tx_done pulse, busy falls.
2. FIFO empty (wait=1) for 5 cycles, then wait=0 with data 0x80 → data_out_read high all 6 cycles and tx_wire=1 throughout. Start bit follows the capture cycle. Data bits are 0×7 then 1, then stop.
3. FIFO holds 0xA5 then 0x3C, wait=0 → exactly two accepted reads. Line frames read 0xA5 then 0x3C LSB-first. Mark gap between stop end and second start = 1 clk.
4. rst asserted during data bit 3 of 0xF0 → next edge tx_wire=1, busy=0, data_out_read=0. After release: IDLE→FETCH, and the next FIFO byte (not 0xF0) is sent.
5. STOP_BITS=2 with 0x00 → stop high for 32 baud_ticks before tx_done pulses.
6. Irregular baud_tick (random gaps 1–9 clk) → each bit still spans exactly 16 ticks. Receiver loopback (uart_recv) reproduces every sent byte.

Source files
------------

// File: rtl/uart_send.sv
// UART transmitter: pops bytes from the FIFO read port and sends them as
// start + DATA_BITS (LSB first) + STOP_BITS frames, timed by baud_tick.
// Ports: clk, rst (sync, active-high), baud_tick, data_out/data_out_wait
//        (FIFO read data / waitrequest), data_out_read, tx_wire, busy, tx_done.
module uart_send #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] data_out,
    input  logic                 data_out_wait,
    output logic                 data_out_read,
    output logic                 tx_wire,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int TW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BMAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 read_q, read_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        bit_end = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                // counters start from zero for the start bit
                tick_d = '0;
                bit_d  = '0;
                if (!data_out_wait) begin
                    shift_d = data_out;
                    state_d = START;
                end
            end
            START, DATA, STOP: begin
                if (baud_tick) begin
                    if (tick_q == TICK_LAST) begin
                        bit_end = 1'b1;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                if (bit_end) begin
                    if (state_q == START) begin
                        state_d = DATA;
                    end else if (state_q == DATA) begin
                        shift_d = shift_q >> 1;
                        if (bit_q == DATA_LAST) begin
                            bit_d   = '0;
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        if (bit_q == STOP_LAST) begin
                            bit_d   = '0;
                            done_d  = 1'b1;
                            state_d = FETCH;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // outputs are registered, so they follow the next state
        read_d = (state_d == FETCH);
        busy_d = (state_d == START) || (state_d == DATA) ||
                 (state_d == STOP);
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            read_q  <= read_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out_read = read_q;
    assign tx_wire       = tx_q;
    assign busy          = busy_q;
    assign tx_done       = done_q;

endmodule

// File: tb/tb_uart_send.sv
// Testbench for uart_send: FIFO bus model, baud tick generator and a
// frame-level reference model; a second instance covers two stop bits.
module tb_uart_send;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic [7:0] data_out;
    logic       data_out_wait;
    logic       data_out_read;
    logic       tx_wire;
    logic       busy;
    logic       tx_done;

    logic [7:0] data2;
    logic       wait2;
    logic       read2;
    logic       tx2;
    logic       busy2;
    logic       done2;

    int errors = 0;
    int checks = 0;

    uart_send #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_tick     (baud_tick),
        .data_out      (data_out),
        .data_out_wait (data_out_wait),
        .data_out_read (data_out_read),
        .tx_wire       (tx_wire),
        .busy          (busy),
        .tx_done       (tx_done)
    );

    uart_send #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(2)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .baud_tick     (baud_tick),
        .data_out      (data2),
        .data_out_wait (wait2),
        .data_out_read (read2),
        .tx_wire       (tx2),
        .busy          (busy2),
        .tx_done       (done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // baud tick source: every 4 clk, or random gaps of 1..9 clk
    bit rand_tick = 1'b0;
    int gen_cnt;
    initial begin
        baud_tick = 1'b0;
        gen_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (gen_cnt == 0) begin
                baud_tick = 1'b1;
                gen_cnt = rand_tick ? int'($urandom_range(8, 0)) : 3;
            end else begin
                baud_tick = 1'b0;
                gen_cnt--;
            end
        end
    end

    // FIFO bus model: waitrequest while empty or forced
    logic [7:0] fifo_q[$];
    bit         force_wait = 1'b0;
    int         n_accept = 0;
    logic [7:0] junk;
    initial begin
        data_out_wait = 1'b1;
        data_out      = '0;
        forever begin
            @(posedge clk);
            if (!rst && data_out_read && !data_out_wait &&
                fifo_q.size() > 0) begin
                junk = fifo_q.pop_front();
                n_accept++;
            end
            #1;
            data_out_wait = force_wait || (fifo_q.size() == 0);
            data_out = (fifo_q.size() > 0) ? fifo_q[0] : 8'($urandom);
        end
    end

    // Reference model: a frame is a list of line levels, each held for
    // 16 baud ticks; a frame begins on the edge the FIFO grants a read.
    typedef enum {M_IDLE, M_FETCH, M_FRAME} mph_t;
    mph_t       m_ph = M_IDLE;
    logic       m_lev[0:15];
    int         m_nlev = 0;
    int         m_idx = 0;
    int         m_ticks = 0;
    logic       m_done = 1'b0;
    int         m_frames_done = 0;
    logic [7:0] m_bytes[$];
    logic [3:0] exp_v = 4'b1000;

    initial begin
        forever begin
            @(posedge clk);
            m_done = 1'b0;
            if (rst) begin
                m_ph = M_IDLE;
            end else begin
                case (m_ph)
                    M_IDLE: m_ph = M_FETCH;
                    M_FETCH: begin
                        if (!data_out_wait) begin
                            m_bytes.push_back(data_out);
                            m_lev[0] = 1'b0;
                            for (int i = 0; i < 8; i++)
                                m_lev[i+1] = data_out[i];
                            m_lev[9] = 1'b1;
                            m_nlev   = 10;
                            m_idx    = 0;
                            m_ticks  = 0;
                            m_ph     = M_FRAME;
                        end
                    end
                    default: begin
                        if (baud_tick) begin
                            m_ticks++;
                            if (m_ticks == 16) begin
                                m_ticks = 0;
                                m_idx++;
                                if (m_idx == m_nlev) begin
                                    m_ph = M_FETCH;
                                    m_done = 1'b1;
                                    m_frames_done++;
                                end
                            end
                        end
                    end
                endcase
            end
            exp_v = {(m_ph == M_FRAME) ? m_lev[m_idx] : 1'b1,
                     m_ph == M_FRAME, m_ph == M_FETCH, m_done};
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_wire, busy, data_out_read, tx_done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state got=%b exp=1000",
                     {tx_wire, busy, data_out_read, tx_done});
        end
        checks++;
        if ({tx2, busy2, read2, done2} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state2 got=%b exp=1000",
                     {tx2, busy2, read2, done2});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_wire, busy, data_out_read, tx_done} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_to_fetch got=%b exp=1010",
                     {tx_wire, busy, data_out_read, tx_done});
        end
    endtask

    task automatic test_single();
        int f0 = m_frames_done;
        int a0 = n_accept;
        int n = 0;
        int low_run = 0;
        bit seen_high = 1'b0;
        fifo_q.push_back(8'h55);
        while (m_frames_done < f0 + 1 && n < 3000) begin
            @(negedge clk);
            n++;
            checks++;
            if ({tx_wire, busy, data_out_read, tx_done} !== exp_v) begin
                errors++;
                $display("FAIL single t=%0t got=%b exp=%b", $time,
                         {tx_wire, busy, data_out_read, tx_done}, exp_v);
            end
            if (busy && !tx_wire && !seen_high) low_run++;
            if (busy && tx_wire) seen_high = 1'b1;
        end
        checks++;
        if (m_frames_done < f0 + 1) begin
            errors++;
            $display("FAIL single_timeout frames=%0d exp=%0d",
                     m_frames_done - f0, 1);
        end
        checks++;
        if (low_run != 64) begin
            errors++;
            $display("FAIL single_start_len got=%0d exp=64", low_run);
        end
        checks++;
        if (n_accept - a0 != 1) begin
            errors++;
            $display("FAIL single_reads got=%0d exp=1", n_accept - a0);
        end
        @(negedge clk);
        checks++;
        if ({tx_done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_done_pulse got=%b exp=00",
                     {tx_done, busy});
        end
    endtask

    task automatic test_stall();
        int f0 = m_frames_done;
        int a0 = n_accept;
        int n = 0;
        force_wait = 1'b1;
        fifo_q.push_back(8'h80);
        repeat (6) begin
            @(negedge clk);
            checks++;
            if ({data_out_read, tx_wire, busy} !== 3'b110) begin
                errors++;
                $display("FAIL stall_hold got=%b exp=110",
                         {data_out_read, tx_wire, busy});
            end
        end
        force_wait = 1'b0;
        while (m_frames_done < f0 + 1 && n < 3000) begin
            @(negedge clk);
            n++;
            checks++;
            if ({tx_wire, busy, data_out_read, tx_done} !== exp_v) begin
                errors++;
                $display("FAIL stall t=%0t got=%b exp=%b", $time,
                         {tx_wire, busy, data_out_read, tx_done}, exp_v);
            end
        end
        checks++;
        if (m_frames_done < f0 + 1 || n_accept - a0 != 1) begin
            errors++;
            $display("FAIL stall_frames frames=%0d reads=%0d exp=1/1",
                     m_frames_done - f0, n_accept - a0);
        end
    endtask

    task automatic test_back_to_back();
        int f0 = m_frames_done;
        int a0 = n_accept;
        int n = 0;
        int gap = 0;
        bit gap_on = 1'b0;
        bit gap_done = 1'b0;
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h3C);
        while (m_frames_done < f0 + 2 && n < 5000) begin
            @(negedge clk);
            n++;
            checks++;
            if ({tx_wire, busy, data_out_read, tx_done} !== exp_v) begin
                errors++;
                $display("FAIL b2b t=%0t got=%b exp=%b", $time,
                         {tx_wire, busy, data_out_read, tx_done}, exp_v);
            end
            if (tx_done && !gap_on && !gap_done) gap_on = 1'b1;
            if (gap_on) begin
                if (tx_wire) begin
                    gap++;
                end else begin
                    gap_on   = 1'b0;
                    gap_done = 1'b1;
                end
            end
        end
        checks++;
        if (gap != 1) begin
            errors++;
            $display("FAIL b2b_gap got=%0d exp=1", gap);
        end
        checks++;
        if (m_frames_done < f0 + 2 || n_accept - a0 != 2) begin
            errors++;
            $display("FAIL b2b_frames frames=%0d reads=%0d exp=2/2",
                     m_frames_done - f0, n_accept - a0);
        end
    endtask

    task automatic test_reset_mid();
        int f0 = m_frames_done;
        int a0 = n_accept;
        int n = 0;
        fifo_q.push_back(8'hF0);
        fifo_q.push_back(8'h5A);
        while (!(m_ph == M_FRAME && m_idx == 4 && m_ticks == 7) &&
               n < 3000) begin
            @(negedge clk);
            n++;
            checks++;
            if ({tx_wire, busy, data_out_read, tx_done} !== exp_v) begin
                errors++;
                $display("FAIL rmid_pre t=%0t got=%b exp=%b", $time,
                         {tx_wire, busy, data_out_read, tx_done}, exp_v);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_wire, busy, data_out_read} !== 3'b100) begin
            errors++;
            $display("FAIL rmid_reset got=%b exp=100",
                     {tx_wire, busy, data_out_read});
        end
        rst = 1'b0;
        n = 0;
        while (m_frames_done < f0 + 1 && n < 3000) begin
            @(negedge clk);
            n++;
            checks++;
            if ({tx_wire, busy, data_out_read, tx_done} !== exp_v) begin
                errors++;
                $display("FAIL rmid_post t=%0t got=%b exp=%b", $time,
                         {tx_wire, busy, data_out_read, tx_done}, exp_v);
            end
        end
        checks++;
        if (m_bytes.size() == 0 || m_bytes[$] !== 8'h5A) begin
            errors++;
            $display("FAIL rmid_next_byte got=%h exp=5a",
                     (m_bytes.size() > 0) ? m_bytes[$] : 8'hxx);
        end
        checks++;
        if (n_accept - a0 != 2) begin
            errors++;
            $display("FAIL rmid_reads got=%0d exp=2", n_accept - a0);
        end
    endtask

    task automatic test_two_stop();
        int n = 0;
        int lowt = 0;
        int hight = 0;
        bit seen_done = 1'b0;
        data2 = 8'h00;
        while (!read2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        wait2 = 1'b0;
        @(posedge clk);
        #1;
        wait2 = 1'b1;
        n = 0;
        while (!seen_done && n < 4000) begin
            @(negedge clk);
            n++;
            if (done2) begin
                seen_done = 1'b1;
            end else if (!tx2) begin
                if (baud_tick) lowt++;
            end else begin
                if (baud_tick) hight++;
            end
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL stop2_timeout got=0 exp=1");
        end
        checks++;
        if (lowt != 144) begin
            errors++;
            $display("FAIL stop2_low_ticks got=%0d exp=144", lowt);
        end
        checks++;
        if (hight != 32) begin
            errors++;
            $display("FAIL stop2_high_ticks got=%0d exp=32", hight);
        end
        checks++;
        if ({busy2, read2, tx2} !== 3'b011) begin
            errors++;
            $display("FAIL stop2_end got=%b exp=011", {busy2, read2, tx2});
        end
    endtask

    task automatic test_random_ticks();
        int f0 = m_frames_done;
        int a0 = n_accept;
        int n = 0;
        int tk = 0;
        logic [7:0] cur = '0;
        logic [7:0] sent[$];
        logic [7:0] dec[$];
        rand_tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sent.push_back(8'($urandom));
            fifo_q.push_back(sent[i]);
        end
        while (m_frames_done < f0 + 4 && n < 20000) begin
            @(negedge clk);
            n++;
            checks++;
            if ({tx_wire, busy, data_out_read, tx_done} !== exp_v) begin
                errors++;
                $display("FAIL rand t=%0t got=%b exp=%b", $time,
                         {tx_wire, busy, data_out_read, tx_done}, exp_v);
            end
            if (busy && baud_tick) begin
                tk++;
                if (tk % 16 == 8 && tk / 16 >= 1 && tk / 16 <= 8)
                    cur[tk/16-1] = tx_wire;
            end
            if (tx_done) begin
                dec.push_back(cur);
                tk = 0;
            end
        end
        rand_tick = 1'b0;
        checks++;
        if (dec.size() != 4 || n_accept - a0 != 4) begin
            errors++;
            $display("FAIL rand_frames got=%0d reads=%0d exp=4/4",
                     dec.size(), n_accept - a0);
        end
        for (int i = 0; i < 4 && i < dec.size(); i++) begin
            checks++;
            if (dec[i] !== sent[i]) begin
                errors++;
                $display("FAIL rand_byte%0d got=%h exp=%h",
                         i, dec[i], sent[i]);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        data2 = '0;
        wait2 = 1'b1;
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_two_stop();
        test_random_ticks();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
